// File: rtl/rib_wait_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rib_wait_sram_pkg
// Description : Shared definitions for the wait-state SRAM bus responder:
//               reset/write polarities, bus widths and FSM state encodings.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package rib_wait_sram_pkg;

  localparam logic RST_ENABLE   = 1'b0;  // active-low reset level
  localparam logic WRITE_ENABLE = 1'b1;  // we_i level that selects a write

  localparam int MEM_BUS_W      = 32;
  localparam int MEM_ADDR_BUS_W = 32;

  typedef logic [MEM_BUS_W-1:0]      mem_bus_t;
  typedef logic [MEM_ADDR_BUS_W-1:0] mem_addr_bus_t;

  typedef enum logic [1:0] {
    RIB_WAIT_IDLE = 2'd0,
    RIB_WAIT_WAIT = 2'd1,
    RIB_WAIT_DONE = 2'd2
  } rib_state_e;

endpackage
`default_nettype wire

// File: rtl/rib_wait_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : rib_wait_sram_if
// Description : Data-access bus between the core (master) and the wait-state
//               SRAM (slave).
// Signals     : req_i/we_i/addr_i/data_i  master -> slave request
//               data_o/hold_o/ack_o       slave -> master response/stall
// Revision    : 1.0  initial release
// ============================================================================
interface rib_wait_sram_if;
  import rib_wait_sram_pkg::*;

  logic          req_i;
  logic          we_i;
  mem_addr_bus_t addr_i;
  mem_bus_t      data_i;
  mem_bus_t      data_o;
  logic          hold_o;
  logic          ack_o;

  modport master (
    output req_i, we_i, addr_i, data_i,
    input  data_o, hold_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, data_i,
    output data_o, hold_o, ack_o
  );
endinterface
`default_nettype wire

// File: rtl/rib_wait_sram_sram_1p.sv
`default_nettype none
// ============================================================================
// Module      : sram_1p
// Description : Synchronous single-port DEPTH x 32 array, one read/write
//               port. Reads return data on the clock after en with we=0.
//               The array is behavioural and is not preloaded; INIT_FILE is
//               carried so a vendor macro wrapper can pick up the image.
// Ports       : clk, rst (sync, active-low, clears the read register only),
//               en, we, addr, din  -> access request
//               dout                -> registered read data
// Revision    : 1.0  initial release
// ============================================================================
module sram_1p
  import rib_wait_sram_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          en,
  input  wire logic          we,
  input  wire logic [AW-1:0] addr,
  input  wire mem_bus_t      din,
  output      mem_bus_t      dout
);

  mem_bus_t mem [DEPTH];

  // Array storage carries no reset so it maps onto a real SRAM macro.
  always_ff @(posedge clk) begin
    if (en && (we == WRITE_ENABLE)) begin
      mem[addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      dout <= '0;
    end else if (en && (we != WRITE_ENABLE)) begin
      dout <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rib_wait_sram.sv
`default_nettype none
// ============================================================================
// Module      : rib_wait_sram
// Description : Bus slave wrapping an on-chip SRAM behind a fixed number of
//               wait states. Each access holds the pipeline for WAIT_CYCLES
//               cycles, then pulses ack for one cycle with read data.
// Ports       : clk   clock
//               rst   synchronous reset, active-low
//               bus   rib_wait_sram_if.slave (req/we/addr/data in,
//                     data/hold/ack out)
// Revision    : 1.0  initial release
// ============================================================================
module rib_wait_sram
  import rib_wait_sram_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input wire logic   clk,
  input wire logic   rst,
  rib_wait_sram_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0);

  rib_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       take;      // accept the request presented in IDLE
  logic       commit;    // this edge enters DONE: perform the array access
  logic       hold;
  logic       ack;
  logic       in_rst;

  logic          we_q;
  logic [AW-1:0] idx_q;
  mem_bus_t      data_q;

  logic          acc_we;
  logic [AW-1:0] acc_idx;
  mem_bus_t      acc_din;
  mem_bus_t      rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};

  assign in_rst = (rst == RST_ENABLE);

  always_ff @(posedge clk) begin
    if (in_rst) begin
      state <= RIB_WAIT_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      we_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (take) begin
      we_q   <= bus.we_i;
      idx_q  <= bus.addr_i[AW+1:2];
      data_q <= bus.data_i;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    commit    = 1'b0;
    hold      = 1'b0;
    ack       = 1'b0;
    case (state)
      RIB_WAIT_IDLE: begin
        hold = bus.req_i;
        if (bus.req_i) begin
          take = 1'b1;
          if (WAIT_CYCLES == 1) begin
            state_nxt = RIB_WAIT_DONE;
            commit    = 1'b1;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = RIB_WAIT_WAIT;
          end
        end
      end
      RIB_WAIT_WAIT: begin
        hold = 1'b1;
        if (!bus.req_i) begin
          // Request withdrawn (flush): drop the access without side effects.
          state_nxt = RIB_WAIT_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = RIB_WAIT_DONE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RIB_WAIT_DONE: begin
        ack       = 1'b1;
        state_nxt = RIB_WAIT_IDLE;
      end
      default: state_nxt = RIB_WAIT_IDLE;
    endcase
  end

  // With one wait state the commit happens on the same edge that latches the
  // request, so the array must see the live bus rather than the latches.
  assign acc_we  = (state == RIB_WAIT_IDLE) ? bus.we_i              : we_q;
  assign acc_idx = (state == RIB_WAIT_IDLE) ? bus.addr_i[AW+1:2]    : idx_q;
  assign acc_din = (state == RIB_WAIT_IDLE) ? bus.data_i            : data_q;

  sram_1p #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .en   (commit && !in_rst),
    .we   (acc_we),
    .addr (acc_idx),
    .din  (acc_din),
    .dout (rdata)
  );

  assign bus.hold_o = hold && !in_rst;
  assign bus.ack_o  = ack && !in_rst;
  assign bus.data_o = (ack && !in_rst && (we_q != WRITE_ENABLE)) ? rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_rib_wait_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_rib_wait_sram
// Description : Self-checking bench for rib_wait_sram. Two instances: one
//               with two wait states (index 0), one with a single wait state
//               (index 1). Stimulus pushes expected ack data into a per-DUT
//               queue; a negedge monitor pops and compares on every ack.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rib_wait_sram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        hold  [2];
  logic        ack   [2];
  logic [31:0] rdata [2];

  rib_wait_sram_if if2 ();
  rib_wait_sram_if if1 ();

  assign if2.req_i  = req[0];
  assign if2.we_i   = we[0];
  assign if2.addr_i = addr[0];
  assign if2.data_i = wdata[0];
  assign hold[0]    = if2.hold_o;
  assign ack[0]     = if2.ack_o;
  assign rdata[0]   = if2.data_o;

  assign if1.req_i  = req[1];
  assign if1.we_i   = we[1];
  assign if1.addr_i = addr[1];
  assign if1.data_i = wdata[1];
  assign hold[1]    = if1.hold_o;
  assign ack[1]     = if1.ack_o;
  assign rdata[1]   = if1.data_o;

  rib_wait_sram #(.DEPTH(1024), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  rib_wait_sram #(.DEPTH(1024), .WAIT_CYCLES(1), .INIT_FILE("")) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation;
  // outside an ack the read bus must stay zero.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d]) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack dut%0d: got ack=1 expected ack=0", d);
        end else if (d == 0) begin
          check("ack_data_dut0", rdata[0], exp_q0.pop_front());
        end else begin
          check("ack_data_dut1", rdata[1], exp_q1.pop_front());
        end
      end else if (rdata[d] !== 32'h0) begin
        vectors++;
        miscompares++;
        $display("FAIL idle_data dut%0d: got %h expected 00000000", d, rdata[d]);
      end
    end
  end

  // Single access with hold/latency measurement. Optionally perturbs the
  // bus inputs during WAIT to confirm they are ignored after capture.
  task automatic access(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd_exp,
                        input bit perturb);
    int wc  = (d == 0) ? 2 : 1;
    int hc  = 0;
    int lat = 0;
    bit got = 0;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = wr; addr[d] = a; wdata[d] = wd;
    push_exp(d, wr ? 32'h0 : rd_exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack[d]) begin got = 1; break; end
      if (hold[d]) hc++;
      lat++;
      if (perturb && i == 1) begin
        wdata[d] = ~wd;
        addr[d]  = a ^ 32'h40;
        we[d]    = ~wr;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout dut%0d: got no ack expected ack within 20 cycles", d);
    end
    check($sformatf("hold_cycles_dut%0d", d), 32'(hc), 32'(wc));
    check($sformatf("ack_latency_dut%0d", d), 32'(lat), 32'(wc));
    @(posedge clk); #1;
    req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end

    // Reset held: outputs zero even with a request present.
    repeat (2) @(posedge clk);
    #1 req[0] = 1'b1;
    @(negedge clk);
    check("rst_hold", 32'(hold[0]), 32'h0);
    check("rst_ack",  32'(ack[0]),  32'h0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst = 1'b1;

    // Idle bus: no hold, no ack, zero data.
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("idle_hold", 32'(hold[d]), 32'h0);
        check("idle_ack",  32'(ack[d]),  32'h0);
      end
    end

    // Two wait states: write then read, inputs perturbed during WAIT.
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b1);
    access(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);

    // Address aliasing: upper bits and byte offset ignored.
    access(0, 1'b1, 32'h0000_1004, 32'hCAFE0001, 32'h0, 1'b0);
    access(0, 1'b0, 32'h0000_0004, 32'h0, 32'hCAFE0001, 1'b0);
    access(0, 1'b0, 32'h0000_0007, 32'h0, 32'hCAFE0001, 1'b0);

    // Flush in WAIT: write of 0x55 over 0xAA must be dropped.
    access(0, 1'b1, 32'h8, 32'hAA, 32'h0, 1'b0);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h55;
    @(negedge clk);
    check("abort_hold_idle", 32'(hold[0]), 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("abort_hold_wait", 32'(hold[0]), 32'h1);
    repeat (3) @(negedge clk);
    check("abort_no_hold", 32'(hold[0]), 32'h0);
    access(0, 1'b0, 32'h8, 32'h0, 32'hAA, 1'b0);

    // Reset during WAIT of a write leaves the word untouched.
    access(0, 1'b1, 32'hC, 32'h33, 32'h0, 1'b0);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'hC; wdata[0] = 32'h99;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_hold", 32'(hold[0]), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    check("post_rst_hold", 32'(hold[0]), 32'h0);
    check("post_rst_ack",  32'(ack[0]),  32'h0);
    access(0, 1'b0, 32'hC, 32'h0, 32'h33, 1'b0);

    // Single wait state: preload, then back-to-back reads with req held.
    access(1, 1'b1, 32'h0, 32'h11, 32'h0, 1'b0);
    access(1, 1'b1, 32'h4, 32'h22, 32'h0, 1'b0);
    @(posedge clk); #1;
    push_exp(1, 32'h11);
    push_exp(1, 32'h22);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    @(negedge clk);
    check("b2b_hold0", 32'(hold[1]), 32'h1);
    @(negedge clk);
    check("b2b_ack0",  32'(ack[1]),  32'h1);
    check("b2b_hold0_done", 32'(hold[1]), 32'h0);
    @(posedge clk); #1;
    addr[1] = 32'h4;
    @(negedge clk);
    check("b2b_hold1", 32'(hold[1]), 32'h1);
    check("b2b_noack", 32'(ack[1]),  32'h0);
    @(negedge clk);
    check("b2b_ack1",  32'(ack[1]),  32'h1);
    @(posedge clk); #1;
    req[1] = 1'b0;

    repeat (4) @(negedge clk);
    check("dut0_queue_empty", 32'(exp_q0.size()), 32'h0);
    check("dut1_queue_empty", 32'(exp_q1.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
